// File: rtl/imem_port_arbiter_if.sv
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Fetch, load/store and memory-side bus of imem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-3:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic          misalign;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, misalign
  );

  // Requesters plus memory
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata, misalign
  );
endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-port word memory between instruction fetch
//               and load/store. Data has priority with a run limit; define
//               ARB_RR_EN for strict alternation under contention instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  imem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  tag_t          r_tag;
  tag_t          w_tag_nxt;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic [AW-1:0] w_gaddr;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_misalign;

`ifdef ARB_RR_EN
  logic r_last_data;  // 1 when the most recent grant went to the data port

  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst_n) begin
      if (bus.if_req && bus.d_req) begin
        w_d_gnt  = !r_last_data;
        w_if_gnt = r_last_data;
      end else begin
        w_if_gnt = bus.if_req;
        w_d_gnt  = bus.d_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b0;
    end else if (w_d_gnt) begin
      r_last_data <= 1'b1;
    end else if (w_if_gnt) begin
      r_last_data <= 1'b0;
    end
  end
`else
  localparam int                c_RUN_W   = $clog2(MAX_DATA_RUN + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_DATA_RUN);

  logic [c_RUN_W-1:0] r_run;

  // Grants are forced low while reset is asserted so outputs read 0 in reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst_n) begin
      if (bus.if_req && bus.d_req) begin
        w_d_gnt  = (r_run != c_RUN_MAX);
        w_if_gnt = (r_run == c_RUN_MAX);
      end else begin
        w_if_gnt = bus.if_req;
        w_d_gnt  = bus.d_req;
      end
    end
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= '0;
    end else if (w_if_gnt || !bus.if_req) begin
      r_run <= '0;
    end else if (w_d_gnt && (r_run != c_RUN_MAX)) begin
      r_run <= r_run + 1'b1;
    end
  end
`endif

  assign w_gaddr     = w_d_gnt ? bus.d_addr : bus.if_addr;

  assign bus.if_gnt  = w_if_gnt;
  assign bus.d_gnt   = w_d_gnt;
  assign bus.m_en    = w_if_gnt | w_d_gnt;
  assign bus.m_we    = w_d_gnt & bus.d_we;
  assign bus.m_addr  = w_gaddr[AW-1:2];
  assign bus.m_wdata = w_d_gnt ? bus.d_wdata : '0;

  always_comb begin
    w_tag_nxt = TAG_NONE;
    if (w_if_gnt) begin
      w_tag_nxt = TAG_FETCH;
    end else if (w_d_gnt && !bus.d_we) begin
      w_tag_nxt = TAG_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= TAG_NONE;
      r_misalign <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_tag      <= w_tag_nxt;
      r_misalign <= (w_if_gnt | w_d_gnt) && (w_gaddr[1:0] != 2'b00);
      if (r_tag == TAG_FETCH) begin
        r_if_rdata <= bus.m_rdata;
      end
      if (r_tag == TAG_DATA) begin
        r_d_rdata <= bus.m_rdata;
      end
    end
  end

  // Memory data passes straight through in the response cycle, then is held.
  assign bus.if_rvalid = (r_tag == TAG_FETCH);
  assign bus.d_rvalid  = (r_tag == TAG_DATA);
  assign bus.if_rdata  = (r_tag == TAG_FETCH) ? bus.m_rdata : r_if_rdata;
  assign bus.d_rdata   = (r_tag == TAG_DATA)  ? bus.m_rdata : r_d_rdata;
  assign bus.misalign  = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed self-checking bench for imem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  imem_port_arbiter #(.AW(32), .DW(32), .MAX_DATA_RUN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  // Synchronous single-port memory: read data valid the cycle after m_en.
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[7:0]];
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_if [$];
  logic [31:0] q_d  [$];
  logic        exp_if_rv = 1'b0;
  logic        exp_d_rv  = 1'b0;
  logic        exp_mis   = 1'b0;
  logic [31:0] last_if   = '0;
  logic [31:0] last_d    = '0;
  logic [9:0]  seq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic e_ig, input logic e_dg);
    logic [31:0] ga;
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #1;
    check("if_gnt", bus.if_gnt, e_ig);
    check("d_gnt",  bus.d_gnt,  e_dg);
    check("m_en",   bus.m_en,   e_ig | e_dg);
    check("m_we",   bus.m_we,   e_dg & dwe);
    ga = e_dg ? da : ifa;
    if (e_ig | e_dg) check("m_addr", bus.m_addr, ga[31:2]);
    if (e_dg && dwe) begin
      check("m_wdata", bus.m_wdata, dwd);
      shadow[ga[9:2]] = dwd;
    end
    if (e_ig)          q_if.push_back(shadow[ga[9:2]]);
    if (e_dg && !dwe)  q_d.push_back(shadow[ga[9:2]]);
    exp_if_rv = e_ig;
    exp_d_rv  = e_dg && !dwe;
    exp_mis   = (e_ig | e_dg) && (ga[1:0] != 2'b00);
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #2;
    check("if_rvalid", bus.if_rvalid, exp_if_rv);
    check("d_rvalid",  bus.d_rvalid,  exp_d_rv);
    check("misalign",  bus.misalign,  exp_mis);
    check("rvalid_excl", bus.if_rvalid & bus.d_rvalid, 1'b0);
    if (bus.if_rvalid) begin
      e = (q_if.size() != 0) ? q_if.pop_front() : 'x;
      check("if_rdata", bus.if_rdata, e);
      last_if = e;
    end else begin
      check("if_rdata_hold", bus.if_rdata, last_if);
    end
    if (bus.d_rvalid) begin
      e = (q_d.size() != 0) ? q_d.pop_front() : 'x;
      check("d_rdata", bus.d_rdata, e);
      last_d = e;
    end else begin
      check("d_rdata_hold", bus.d_rdata, last_d);
    end
    exp_if_rv = 1'b0;
    exp_d_rv  = 1'b0;
    exp_mis   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_gnt"},    bus.if_gnt,    1'b0);
    check({tag, "_d_gnt"},     bus.d_gnt,     1'b0);
    check({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    check({tag, "_d_rvalid"},  bus.d_rvalid,  1'b0);
    check({tag, "_m_en"},      bus.m_en,      1'b0);
    check({tag, "_m_we"},      bus.m_we,      1'b0);
    check({tag, "_misalign"},  bus.misalign,  1'b0);
    check({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
    check({tag, "_d_rdata"},   bus.d_rdata,   32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'hC0DE_0000 + i;
      shadow[i] = 32'hC0DE_0000 + i;
    end
    mem[2]    = 32'h00A0_2103;
    shadow[2] = 32'h00A0_2103;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #2;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Both requesters held for 10 cycles
`ifdef ARB_RR_EN
    seq = 10'b0101010101;
`else
    seq = 10'b0111101111;
`endif
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, !seq[i], seq[i]);
      tick();
    end

    // Fetch only
    drive(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Store then load of the same word
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h28, 32'hAB, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // Misaligned load
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0B, 32'h0, 1'b0, 1'b1);
    tick();

    // Fetch then load back-to-back
    drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0C, 1'b1, 1'b0, 32'h2C, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // Reset right after a fetch grant drops the pending response
    drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    q_if.delete();
    q_d.delete();
    exp_if_rv = 1'b0;
    exp_d_rv  = 1'b0;
    exp_mis   = 1'b0;
    #1;
    check("rst_if_gnt", bus.if_gnt, 1'b0);
    check("rst_m_en",   bus.m_en,   1'b0);
    @(posedge clk); #2;
    check("rst_if_rvalid", bus.if_rvalid, 1'b0);
    bus.if_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check_idle_outputs("post_rst");
    last_if = '0;
    last_d  = '0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
